// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment patterns,
// digit-index constants and scan FSM state encodings.
package seg7_pkg;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  localparam int         NUM_DIGITS     = 6;
  localparam logic [2:0] DIG_SEC_UNITS  = 3'd0;
  localparam logic [2:0] DIG_COLON_A    = 3'd2;
  localparam logic [2:0] DIG_COLON_B    = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS  = 3'd5;
  localparam logic [2:0] DIG_LAST       = 3'd5;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment decoder with a blank
// override used for leading-zero suppression.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_OFF : seg_pattern(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit time-multiplexed 7-segment scan driver with dead time between
// digits and a once-per-frame time snapshot. Optional macro COLON_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYC    = 16,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic       CLK_50,
  input  logic       CR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  output logic [7:0] hex,
  output logic [5:0] segctrl,
  output logic       frame_done
);

  localparam int DIV         = CLK_HZ / SCAN_HZ;
  localparam int PW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEAD_LAST_I = (DEAD_CYC > 0) ? DEAD_CYC - 1 : 0;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_LAST_I);
  localparam logic [7:0]    HEX_IDLE  = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]    DIG_IDLE  = DIG_ACT_LOW ? 6'h3F : 6'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] dead_q, dead_d;
  logic [2:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic          started_q, started_d;
  logic [23:0]   snap_q, snap_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    hex_q, hex_d;
  logic [5:0]    segctrl_q, segctrl_d;

  logic          tick;
  logic [3:0]    nibble;
  logic          blank;
  logic          colon;
  logic [6:0]    seg7;
  logic [7:0]    seg_act;
  logic [5:0]    dig_act;

  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      presc_q      <= '0;
      dead_q       <= '0;
      idx_q        <= '0;
      state_q      <= ST_DEAD;
      started_q    <= 1'b0;
      snap_q       <= '0;
      frame_done_q <= 1'b0;
      hex_q        <= HEX_IDLE;
      segctrl_q    <= DIG_IDLE;
    end else begin
      presc_q      <= presc_d;
      dead_q       <= dead_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      started_q    <= started_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      hex_q        <= hex_d;
      segctrl_q    <= segctrl_d;
    end
  end

  // Digit stepping, dead-time FSM and frame snapshot. Until the first tick
  // after reset the FSM stays dark, so scanning resumes on digit 1.
  always_comb begin
    tick         = (presc_q == PRESC_MAX);
    presc_d      = tick ? '0 : presc_q + 1'b1;
    dead_d       = dead_q;
    idx_d        = idx_q;
    state_d      = state_q;
    started_d    = started_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;

    if (tick) begin
      idx_d     = (idx_q == DIG_LAST) ? '0 : idx_q + 1'b1;
      state_d   = (DEAD_CYC == 0) ? ST_SHOW : ST_DEAD;
      dead_d    = '0;
      started_d = 1'b1;
      if (idx_q == DIG_LAST) begin
        snap_d       = {Hour, Minute, Second};
        frame_done_d = 1'b1;
      end
    end else if (state_q == ST_DEAD && started_q) begin
      if (dead_q == DEAD_LAST) begin
        state_d = ST_SHOW;
      end else begin
        dead_d = dead_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    nibble = snap_q[3:0];
      3'd1:    nibble = snap_q[7:4];
      3'd2:    nibble = snap_q[11:8];
      3'd3:    nibble = snap_q[15:12];
      3'd4:    nibble = snap_q[19:16];
      3'd5:    nibble = snap_q[23:20];
      default: nibble = 4'd0;
    endcase
    blank = (idx_q == DIG_HOUR_TENS) && (nibble == 4'd0);
  end

  seg7_decode u_decode (
    .nibble_i (nibble),
    .blank_i  (blank),
    .seg_o    (seg7)
  );

  // Output stage: active-high internally, polarity applied last, registered
  // so outputs trail the state/index registers by one cycle.
  always_comb begin
`ifdef COLON_BLINK_EN
    colon = ((idx_q == DIG_COLON_A) || (idx_q == DIG_COLON_B)) && !snap_q[0];
`else
    colon = 1'b0;
`endif
    seg_act   = '0;
    dig_act   = '0;
    if (state_q == ST_SHOW) begin
      seg_act = {colon, seg7};
      dig_act = 6'b000001 << idx_q;
    end
    hex_d     = SEG_ACT_LOW ? ~seg_act : seg_act;
    segctrl_d = DIG_ACT_LOW ? ~dig_act : dig_act;
  end

  assign hex        = hex_q;
  assign segctrl    = segctrl_q;
  assign frame_done = frame_done_q;

endmodule
